// File: rtl/reorder_buffer_pkg.sv
// Shared widths, defaults and entry layout for the reorder buffer.
package reorder_buffer_pkg;

    localparam int unsigned ROB_SIZE_DEFAULT = 16;
    localparam int unsigned ROB_W_DEFAULT    = 4;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned REG_W            = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_W-1:0]  reg_idx_t;

    localparam data_t    DATA_ZERO = '0;
    localparam reg_idx_t REG_ZERO  = '0;

    typedef struct packed {
        logic     busy;
        logic     ready;
        reg_idx_t dest_reg;
        data_t    value;
        logic     is_branch;
        logic     pred_taken;
        logic     taken;
        data_t    target;
    } rob_entry_t;

    localparam rob_entry_t ENTRY_ZERO = '0;

    // A branch whose resolved direction disagrees with the prediction.
    function automatic logic entry_mispredicted(input rob_entry_t e);
        return e.is_branch && (e.taken != e.pred_taken);
    endfunction

endpackage

// File: rtl/rob_entry_array.sv
// Entry storage for the reorder buffer: allocate, CDB completion, retire,
// flush, a head read port and two operand query ports with CDB forwarding.
module rob_entry_array
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_SIZE = ROB_SIZE_DEFAULT,
    parameter int unsigned ROB_W    = ROB_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic              alloc_en,
    input  logic [ROB_W-1:0]  alloc_tag,
    input  logic [REG_W-1:0]  alloc_dest_reg,
    input  logic              alloc_is_branch,
    input  logic              alloc_pred_taken,
    input  logic              retire_en,
    input  logic [ROB_W-1:0]  retire_tag,
    input  logic              cdb_flag,
    input  logic [ROB_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_taken,
    input  logic [DATA_W-1:0] cdb_target,
    input  logic [ROB_W-1:0]  head_tag,
    output rob_entry_t        head_entry,
    input  logic [ROB_W-1:0]  query_tag1,
    input  logic [ROB_W-1:0]  query_tag2,
    output logic              query_ready1,
    output logic [DATA_W-1:0] query_value1,
    output logic              query_ready2,
    output logic [DATA_W-1:0] query_value2
);

    rob_entry_t entries [ROB_SIZE];

    // Entry updates; later writes win, so a same-edge allocation into a
    // slot that is retiring (full buffer, tail == head) takes the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= ENTRY_ZERO;
            end
        end else if (en) begin
            if (clear) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    entries[i].busy  <= 1'b0;
                    entries[i].ready <= 1'b0;
                end
            end else begin
                if (cdb_flag && entries[cdb_tag].busy) begin
                    entries[cdb_tag].ready  <= 1'b1;
                    entries[cdb_tag].value  <= cdb_value;
                    entries[cdb_tag].taken  <= cdb_taken;
                    entries[cdb_tag].target <= cdb_target;
                end
                if (retire_en) begin
                    entries[retire_tag].busy  <= 1'b0;
                    entries[retire_tag].ready <= 1'b0;
                    entries[retire_tag].value <= DATA_ZERO;
                end
                if (alloc_en) begin
                    entries[alloc_tag] <= '{
                        busy:       1'b1,
                        ready:      1'b0,
                        dest_reg:   alloc_dest_reg,
                        value:      DATA_ZERO,
                        is_branch:  alloc_is_branch,
                        pred_taken: alloc_pred_taken,
                        taken:      1'b0,
                        target:     DATA_ZERO
                    };
                end
            end
        end
    end

    assign head_entry = entries[head_tag];

    // Operand lookup; a result on the CDB this cycle overrides stored state.
    always_comb begin
        query_ready1 = entries[query_tag1].ready;
        query_value1 = entries[query_tag1].value;
        query_ready2 = entries[query_tag2].ready;
        query_value2 = entries[query_tag2].value;
        if (cdb_flag && (cdb_tag == query_tag1)) begin
            query_ready1 = 1'b1;
            query_value1 = cdb_value;
        end
        if (cdb_flag && (cdb_tag == query_tag2)) begin
            query_ready2 = 1'b1;
            query_value2 = cdb_value;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates in program order, accepts out-of-order results
// from the CDB, retires in order through a registered commit port, and
// raises a one-cycle redirect on a mispredicted branch, flushing everything
// at the end of that cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_SIZE = ROB_SIZE_DEFAULT,
    parameter int unsigned ROB_W    = ROB_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_decoder_flag,
    input  logic [REG_W-1:0]  in_decoder_dest_reg,
    input  logic              in_decoder_is_branch,
    input  logic              in_decoder_pred_taken,
    output logic [ROB_W-1:0]  out_decoder_tag,
    output logic              out_full,
    input  logic [ROB_W-1:0]  in_query_tag1,
    input  logic [ROB_W-1:0]  in_query_tag2,
    output logic              out_query_ready1,
    output logic [DATA_W-1:0] out_query_value1,
    output logic              out_query_ready2,
    output logic [DATA_W-1:0] out_query_value2,
    input  logic              in_cdb_flag,
    input  logic [ROB_W-1:0]  in_cdb_tag,
    input  logic [DATA_W-1:0] in_cdb_value,
    input  logic              in_cdb_taken,
    input  logic [DATA_W-1:0] in_cdb_target,
    output logic [REG_W-1:0]  out_commit_reg,
    output logic [ROB_W-1:0]  out_commit_tag,
    output logic [DATA_W-1:0] out_commit_value,
    output logic              out_xbp,
    output logic [DATA_W-1:0] out_xbp_pc
);

    localparam logic [ROB_W-1:0] PTR_ONE  = ROB_W'(1);
    localparam logic [ROB_W:0]   CNT_ONE  = (ROB_W + 1)'(1);
    localparam logic [ROB_W:0]   CNT_FULL = (ROB_W + 1)'(ROB_SIZE);

    logic [ROB_W-1:0]  head_q;
    logic [ROB_W-1:0]  tail_q;
    logic [ROB_W:0]    count_q;
    logic              flush;
    logic              commit_fire;
    logic              alloc_fire;
    rob_entry_t        head_entry;
    logic [REG_W-1:0]  commit_reg_q;
    logic [ROB_W-1:0]  commit_tag_q;
    logic [DATA_W-1:0] commit_value_q;
    logic              xbp_q;
    logic [DATA_W-1:0] xbp_pc_q;

    assign out_full        = (count_q == CNT_FULL);
    assign out_decoder_tag = tail_q;

    // The redirect cycle itself is the flush cycle: nothing commits,
    // allocates or completes until the buffer has been emptied.
    assign flush       = xbp_q;
    assign commit_fire = !flush && head_entry.busy && head_entry.ready;
    // A full buffer still accepts one allocation when the head retires.
    assign alloc_fire  = !flush && in_decoder_flag && (!out_full || commit_fire);

    rob_entry_array #(
        .ROB_SIZE (ROB_SIZE),
        .ROB_W    (ROB_W)
    ) u_entries (
        .clk              (clk),
        .rst              (rst),
        .en               (rdy),
        .clear            (flush),
        .alloc_en         (alloc_fire),
        .alloc_tag        (tail_q),
        .alloc_dest_reg   (in_decoder_dest_reg),
        .alloc_is_branch  (in_decoder_is_branch),
        .alloc_pred_taken (in_decoder_pred_taken),
        .retire_en        (commit_fire),
        .retire_tag       (head_q),
        .cdb_flag         (in_cdb_flag),
        .cdb_tag          (in_cdb_tag),
        .cdb_value        (in_cdb_value),
        .cdb_taken        (in_cdb_taken),
        .cdb_target       (in_cdb_target),
        .head_tag         (head_q),
        .head_entry       (head_entry),
        .query_tag1       (in_query_tag1),
        .query_tag2       (in_query_tag2),
        .query_ready1     (out_query_ready1),
        .query_value1     (out_query_value1),
        .query_ready2     (out_query_ready2),
        .query_value2     (out_query_value2)
    );

    // Head, tail and occupancy; pointers wrap naturally at ROB_SIZE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (commit_fire) begin
                    head_q <= head_q + PTR_ONE;
                end
                if (alloc_fire) begin
                    tail_q <= tail_q + PTR_ONE;
                end
                if (alloc_fire && !commit_fire) begin
                    count_q <= count_q + CNT_ONE;
                end else if (commit_fire && !alloc_fire) begin
                    count_q <= count_q - CNT_ONE;
                end
            end
        end
    end

    // Registered commit port and mispredict redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_reg_q   <= REG_ZERO;
            commit_tag_q   <= '0;
            commit_value_q <= DATA_ZERO;
            xbp_q          <= 1'b0;
            xbp_pc_q       <= DATA_ZERO;
        end else if (rdy) begin
            if (commit_fire) begin
                commit_reg_q   <= head_entry.dest_reg;
                commit_tag_q   <= head_q;
                commit_value_q <= head_entry.value;
                xbp_q          <= entry_mispredicted(head_entry);
                if (entry_mispredicted(head_entry)) begin
                    xbp_pc_q <= head_entry.target;
                end
            end else begin
                commit_reg_q <= REG_ZERO;
                xbp_q        <= 1'b0;
            end
        end
    end

    // A stalled cycle shows no commit; the held result appears once rdy returns.
    assign out_commit_reg   = rdy ? commit_reg_q : REG_ZERO;
    assign out_commit_tag   = commit_tag_q;
    assign out_commit_value = commit_value_q;
    assign out_xbp          = rdy && xbp_q;
    assign out_xbp_pc       = xbp_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomised scoreboard bench for reorder_buffer against a queue-based model.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int unsigned N = 16;
    localparam int unsigned W = 4;

    logic          clk;
    logic          rst;
    logic          rdy;
    logic          dec_flag;
    logic [4:0]    dec_dest;
    logic          dec_br;
    logic          dec_pred;
    logic [W-1:0]  dec_tag;
    logic          full;
    logic [W-1:0]  q_tag1;
    logic [W-1:0]  q_tag2;
    logic          q_rdy1;
    logic          q_rdy2;
    logic [31:0]   q_val1;
    logic [31:0]   q_val2;
    logic          cdb_flag;
    logic [W-1:0]  cdb_tag;
    logic [31:0]   cdb_value;
    logic          cdb_taken;
    logic [31:0]   cdb_target;
    logic [4:0]    c_reg;
    logic [W-1:0]  c_tag;
    logic [31:0]   c_val;
    logic          xbp;
    logic [31:0]   xbp_pc;

    reorder_buffer #(
        .ROB_SIZE (N),
        .ROB_W    (W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .in_decoder_flag       (dec_flag),
        .in_decoder_dest_reg   (dec_dest),
        .in_decoder_is_branch  (dec_br),
        .in_decoder_pred_taken (dec_pred),
        .out_decoder_tag       (dec_tag),
        .out_full              (full),
        .in_query_tag1         (q_tag1),
        .in_query_tag2         (q_tag2),
        .out_query_ready1      (q_rdy1),
        .out_query_value1      (q_val1),
        .out_query_ready2      (q_rdy2),
        .out_query_value2      (q_val2),
        .in_cdb_flag           (cdb_flag),
        .in_cdb_tag            (cdb_tag),
        .in_cdb_value          (cdb_value),
        .in_cdb_taken          (cdb_taken),
        .in_cdb_target         (cdb_target),
        .out_commit_reg        (c_reg),
        .out_commit_tag        (c_tag),
        .out_commit_value      (c_val),
        .out_xbp               (xbp),
        .out_xbp_pc            (xbp_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: in-flight instructions in program order.
    typedef struct {
        int        tag;
        int        dest;
        bit        br;
        bit        pred;
        bit        done;
        bit [31:0] val;
        bit        tk;
        bit [31:0] tgt;
    } op_t;

    typedef struct {
        int        cyc;
        int        rg;
        int        tag;
        bit [31:0] val;
        bit        xbp;
        bit [31:0] pc;
    } exp_t;

    op_t  rob[$];
    exp_t expq[$];
    int   pend[$];
    int   model_tail;
    bit   flush_pend;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic set_idle();
        rdy        = 1'b1;
        dec_flag   = 1'b0;
        dec_dest   = 5'd0;
        dec_br     = 1'b0;
        dec_pred   = 1'b0;
        cdb_flag   = 1'b0;
        cdb_tag    = '0;
        cdb_value  = 32'd0;
        cdb_taken  = 1'b0;
        cdb_target = 32'd0;
        q_tag1     = '0;
        q_tag2     = '0;
    endtask

    task automatic drive_alloc(input int dest, input bit br, input bit pred);
        dec_flag = 1'b1;
        dec_dest = 5'(dest);
        dec_br   = br;
        dec_pred = pred;
    endtask

    task automatic drive_cdb(input int tag, input bit [31:0] val, input bit tk,
                             input bit [31:0] tgt);
        cdb_flag   = 1'b1;
        cdb_tag    = W'(tag);
        cdb_value  = val;
        cdb_taken  = tk;
        cdb_target = tgt;
    endtask

    task automatic check_query(input string name, input int qt, input logic r,
                               input logic [31:0] v);
        bit        er;
        bit [31:0] ev;
        er = 1'b0;
        ev = 32'd0;
        if (cdb_flag && int'(cdb_tag) == qt) begin
            er = 1'b1;
            ev = cdb_value;
        end else begin
            foreach (rob[i]) begin
                if (rob[i].tag == qt && rob[i].done) begin
                    er = 1'b1;
                    ev = rob[i].val;
                end
            end
        end
        check({name, "_ready"}, r, er);
        if (er) check({name, "_value"}, v, ev);
    endtask

    task automatic check_static();
        if (!rst) return;
        check("out_full", full, (rob.size() == N));
        check("out_decoder_tag", dec_tag, model_tail);
        check_query("query1", int'(q_tag1), q_rdy1, q_val1);
        check_query("query2", int'(q_tag2), q_rdy2, q_val2);
    endtask

    // One clock edge of the architectural rules: flush, retire oldest,
    // complete, then append.
    task automatic model_edge();
        op_t  e;
        op_t  n;
        exp_t x;
        bit   mis;
        if (!rst || !rdy) return;
        if (flush_pend) begin
            rob.delete();
            model_tail = 0;
            flush_pend = 1'b0;
            return;
        end
        if (rob.size() > 0 && rob[0].done) begin
            e = rob.pop_front();
            mis = e.br && (e.tk != e.pred);
            if (e.dest != 0 || mis) begin
                x.cyc = cyc + 1;
                x.rg  = e.dest;
                x.tag = e.tag;
                x.val = e.val;
                x.xbp = mis;
                x.pc  = e.tgt;
                expq.push_back(x);
            end
            flush_pend = mis;
        end
        if (cdb_flag) begin
            foreach (rob[i]) begin
                if (rob[i].tag == int'(cdb_tag)) begin
                    rob[i].done = 1'b1;
                    rob[i].val  = cdb_value;
                    rob[i].tk   = cdb_taken;
                    rob[i].tgt  = cdb_target;
                end
            end
        end
        if (dec_flag && rob.size() < N) begin
            n.tag  = model_tail;
            n.dest = int'(dec_dest);
            n.br   = dec_br;
            n.pred = dec_pred;
            n.done = 1'b0;
            n.val  = 32'd0;
            n.tk   = 1'b0;
            n.tgt  = 32'd0;
            rob.push_back(n);
            model_tail = (model_tail + 1) % N;
        end
    endtask

    task automatic step();
        #1;
        check_static();
        model_edge();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        rob.delete();
        expq.delete();
        model_tail = 0;
        flush_pend = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic pick_cdb();
        pend.delete();
        foreach (rob[i]) if (!rob[i].done) pend.push_back(rob[i].tag);
        if (pend.size() > 0 && $urandom_range(0, 7) != 0)
            drive_cdb(pend[$urandom_range(0, pend.size() - 1)], $urandom,
                      1'($urandom_range(0, 1)), $urandom);
        else
            drive_cdb(int'($urandom_range(0, N - 1)), $urandom, 1'($urandom_range(0, 1)),
                      $urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && (rob.size() > 0 || flush_pend || expq.size() > 0); k++) begin
            set_idle();
            pick_cdb();
            step();
        end
        set_idle();
        step();
        step();
    endtask

    // Monitor: pops the oldest expected commit whenever the DUT shows one.
    always @(negedge clk) begin
        if (rst) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_commit at cycle %0d: got nothing, want reg %0d tag %0d",
                         cyc, expq[0].rg, expq[0].tag);
                void'(expq.pop_front());
            end
            if (!rdy) begin
                check("stall_commit_reg", c_reg, 0);
                check("stall_xbp", xbp, 0);
                if (expq.size() > 0 && expq[0].cyc == cyc) expq[0].cyc++;
            end else if (c_reg != 5'd0 || xbp) begin
                if (expq.size() == 0 || expq[0].cyc != cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_commit at cycle %0d: got reg %0d xbp %0d, want none",
                             cyc, c_reg, xbp);
                end else begin
                    check("commit_reg", c_reg, expq[0].rg);
                    check("commit_tag", c_tag, expq[0].tag);
                    check("commit_value", c_val, expq[0].val);
                    check("commit_xbp", xbp, expq[0].xbp);
                    if (expq[0].xbp) check("xbp_pc", xbp_pc, expq[0].pc);
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        cyc        = 0;
        model_tail = 0;
        flush_pend = 1'b0;
        set_idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        step();
        check("reset_commit_reg", c_reg, 0);
        check("reset_xbp", xbp, 0);
        check("reset_xbp_pc", xbp_pc, 0);
        check("reset_full", full, 0);
        check("reset_decoder_tag", dec_tag, 0);
        rst = 1'b1;

        // x5 completes with 0x2A and retires the following cycle.
        set_idle(); drive_alloc(5, 0, 0); step();
        set_idle(); drive_cdb(0, 32'h2A, 0, 0); step();
        set_idle(); step(); step();

        // Fill, overflow request, then retire and allocate together.
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_idle(); drive_alloc(i + 1, 0, 0); step();
        end
        set_idle(); drive_alloc(30, 0, 0); step();
        set_idle(); drive_cdb(0, 32'hA0, 0, 0); step();
        set_idle(); drive_alloc(9, 0, 0); step();
        set_idle(); step();
        drain();

        // Younger result first; retirement stays in order.
        do_reset();
        set_idle(); drive_alloc(1, 0, 0); step();
        set_idle(); drive_alloc(2, 0, 0); step();
        set_idle(); drive_cdb(1, 32'h11, 0, 0); step();
        set_idle(); drive_cdb(0, 32'h10, 0, 0); step();
        set_idle(); step(); step(); step();

        // Mispredicted branch redirects to 0x100 and drops younger work.
        do_reset();
        set_idle(); drive_alloc(0, 1, 0); step();
        set_idle(); drive_alloc(3, 0, 0); step();
        set_idle(); drive_alloc(4, 0, 0); step();
        set_idle(); drive_cdb(1, 32'h33, 0, 0); step();
        set_idle(); drive_cdb(0, 32'h0, 1, 32'h100); step();
        set_idle(); step();
        set_idle(); drive_alloc(6, 0, 0); step();
        set_idle(); drive_cdb(1, 32'h44, 0, 0); q_tag1 = W'(1); step();
        set_idle(); step(); step();

        // Same-cycle CDB forwarding into a query.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_idle(); drive_alloc(i + 8, 0, 0); step();
        end
        set_idle(); drive_cdb(3, 32'h77, 0, 0); q_tag1 = W'(3); q_tag2 = W'(2); step();
        drain();

        // Asynchronous reset with live entries.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_idle(); drive_alloc(i + 1, 0, 0); step();
        end
        set_idle();
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_commit_reg", c_reg, 0);
        check("async_rst_xbp", xbp, 0);
        check("async_rst_full", full, 0);
        check("async_rst_decoder_tag", dec_tag, 0);
        rob.delete();
        expq.delete();
        model_tail = 0;
        flush_pend = 1'b0;
        step();
        step();
        rst = 1'b1;
        set_idle(); drive_alloc(7, 0, 0); step();
        set_idle(); drive_cdb(0, 32'h55, 0, 0); step();
        set_idle(); step(); step();

        // Random traffic with stalls, mispredicts and stray CDB tags.
        for (int k = 0; k < 3000; k++) begin
            set_idle();
            rdy = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) < 6)
                drive_alloc(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)),
                            ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) < 5) pick_cdb();
            q_tag1 = W'($urandom_range(0, N - 1));
            q_tag2 = (cdb_flag && $urandom_range(0, 1) == 0) ? cdb_tag
                                                             : W'($urandom_range(0, N - 1));
            step();
        end
        drain();
        check("unmatched_expected_commits", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
